// File: rtl/bus_demux.sv
// bus_demux: owns one Wishbone-classic transaction from a single initiator, routes it to the
// decoder-selected responder, returns that responder's data/ack/err and times out dead ports.
module bus_demux #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 30,
  parameter bit PRIORITY  = 1'b0,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORTS-1:0]           select_i,
  input  logic                           cyc_i,
  input  logic                           stb_i,
  input  logic                           we_i,
  input  logic [DATA_BITS/8-1:0]         sel_i,
  input  logic [ADDR_BITS-1:0]           addr_i,
  input  logic [DATA_BITS-1:0]           data_i,
  output logic [DATA_BITS-1:0]           data_o,
  output logic                           ack_o,
  output logic                           err_o,
  output logic                           busy_o,
  output logic [NUM_PORTS-1:0]           port_cyc_o,
  output logic [NUM_PORTS-1:0]           port_stb_o,
  output logic                           port_we_o,
  output logic [DATA_BITS/8-1:0]         port_sel_o,
  output logic [ADDR_BITS-1:0]           port_addr_o,
  output logic [DATA_BITS-1:0]           port_data_o,
  input  logic [NUM_PORTS*DATA_BITS-1:0] port_data_i,
  input  logic [NUM_PORTS-1:0]           port_ack_i,
  input  logic [NUM_PORTS-1:0]           port_err_i
);

  localparam int TIMER_BITS = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [NUM_PORTS-1:0]  grant_oh, cyc_d;
  logic [DATA_BITS-1:0]  data_d, grant_data;
  logic                  request, select_ok, port_ack, port_err, timed_out;
  logic                  ack_d, err_d;

  // Lowest set select bit is the grant; without PRIORITY the select must already be one-hot.
  assign request   = cyc_i & stb_i;
  assign grant_oh  = select_i & (~select_i + NUM_PORTS'(1));
  assign select_ok = PRIORITY ? (|select_i) : ((|select_i) && (grant_oh == select_i));

  // port_cyc_o doubles as the latched one-hot grant, so responses from other ports are masked.
  assign port_ack  = |(port_ack_i & port_cyc_o);
  assign port_err  = |(port_err_i & port_cyc_o);
  assign timed_out = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

  always_comb begin
    grant_data = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (port_cyc_o[n]) grant_data = port_data_i[n*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (request) state_d = select_ok ? ACTIVE : DONE;
      end
      ACTIVE: begin
        if (!cyc_i)                                     state_d = IDLE;
        else if (port_ack || port_err || timed_out)     state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; abort beats a response, a response beats the timeout.
  always_comb begin
    cyc_d   = port_cyc_o;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = data_o;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (request) begin
          if (select_ok) begin
            cyc_d   = grant_oh;
            timer_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (timer_q != '1) timer_d = timer_q + TIMER_BITS'(1);
        if (!cyc_i) begin
          cyc_d = '0;
        end else if (port_ack || port_err) begin
          cyc_d  = '0;
          data_d = grant_data;
          err_d  = port_err;
          ack_d  = !port_err;
        end else if (timed_out) begin
          cyc_d = '0;
          err_d = 1'b1;
        end
      end
      default: cyc_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_cyc_o  <= '0;
      port_stb_o  <= '0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      data_o      <= '0;
      timer_q     <= '0;
      port_we_o   <= 1'b0;
      port_sel_o  <= '0;
      port_addr_o <= '0;
      port_data_o <= '0;
    end else begin
      port_cyc_o <= cyc_d;
      port_stb_o <= cyc_d;
      ack_o      <= ack_d;
      err_o      <= err_d;
      busy_o     <= (state_d != IDLE);
      data_o     <= data_d;
      timer_q    <= timer_d;
      if (state_q == IDLE && request && select_ok) begin
        port_we_o   <= we_i;
        port_sel_o  <= sel_i;
        port_addr_o <= addr_i;
        port_data_o <= data_i;
      end
    end
  end

endmodule
